// File: rtl/bp_me_pkg.sv
// Shared memory-engine types for the cache DMA arbiter.
package bp_me_pkg;

    typedef enum logic [0:0] {
        e_arb,
        e_wr_data
    } bp_me_dma_arb_state_e;

    function automatic int bp_me_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_me_cache_dma_arbiter_rr_grant.sv
// Round-robin grant: first requester at or after ptr_i, wrapping.
module bp_me_rr_grant
    import bp_me_pkg::*;
#(
    parameter int num_p = 2
) (
    input  logic [num_p-1:0]                  req_i,
    input  logic [bp_me_id_width(num_p)-1:0]  ptr_i,
    output logic [num_p-1:0]                  grant_oh_o,
    output logic [bp_me_id_width(num_p)-1:0]  grant_id_o,
    output logic                              any_o
);

    localparam int id_w = bp_me_id_width(num_p);
    localparam logic [id_w:0] num_w = (id_w + 1)'(num_p);

    logic [id_w:0] idx;

    always_comb begin
        grant_oh_o = '0;
        grant_id_o = '0;
        any_o      = 1'b0;
        idx        = '0;
        for (int k = 0; k < num_p; k++) begin
            idx = {1'b0, ptr_i} + (id_w + 1)'(k);
            if (idx >= num_w) begin
                idx = idx - num_w;
            end
            if (!any_o && req_i[idx[id_w-1:0]]) begin
                any_o                      = 1'b1;
                grant_id_o                 = idx[id_w-1:0];
                grant_oh_o[idx[id_w-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_me_cache_dma_arbiter.sv
// Shares one DRAM DMA port among L2 slices; in-order read return
// steered by a FIFO of requesting slice ids.
module bp_me_cache_dma_arbiter
    import bp_me_pkg::*;
#(
    parameter int num_slices_p   = 2,
    parameter int header_width_p = 128,
    parameter int data_width_p   = 64,
    parameter int block_words_p  = 8,
    parameter int max_reads_p    = 4
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,

    input  logic [num_slices_p*header_width_p-1:0]  slice_cmd_header_i,
    input  logic [num_slices_p-1:0]                 slice_cmd_wr_i,
    input  logic [num_slices_p-1:0]                 slice_cmd_header_v_i,
    output logic [num_slices_p-1:0]                 slice_cmd_header_yumi_o,
    input  logic [num_slices_p*data_width_p-1:0]    slice_cmd_data_i,
    input  logic [num_slices_p-1:0]                 slice_cmd_data_v_i,
    output logic [num_slices_p-1:0]                 slice_cmd_data_yumi_o,
    output logic [data_width_p-1:0]                 slice_resp_data_o,
    output logic [num_slices_p-1:0]                 slice_resp_data_v_o,
    input  logic [num_slices_p-1:0]                 slice_resp_data_ready_i,

    output logic [header_width_p-1:0]               mem_cmd_header_o,
    output logic                                    mem_cmd_header_v_o,
    input  logic                                    mem_cmd_header_yumi_i,
    output logic [data_width_p-1:0]                 mem_cmd_data_o,
    output logic                                    mem_cmd_data_v_o,
    input  logic                                    mem_cmd_data_yumi_i,
    input  logic [header_width_p-1:0]               mem_resp_header_i,
    input  logic                                    mem_resp_header_v_i,
    output logic                                    mem_resp_header_ready_o,
    input  logic [data_width_p-1:0]                 mem_resp_data_i,
    input  logic                                    mem_resp_data_v_i,
    output logic                                    mem_resp_data_ready_o
);

    localparam int id_w  = bp_me_id_width(num_slices_p);
    localparam int cnt_w = bp_me_id_width(block_words_p);
    localparam int ptr_w = bp_me_id_width(max_reads_p);
    localparam int occ_w = $clog2(max_reads_p + 1);

    localparam logic [cnt_w-1:0] last_beat  = cnt_w'(block_words_p - 1);
    localparam logic [id_w-1:0]  last_id    = id_w'(num_slices_p - 1);
    localparam logic [ptr_w-1:0] last_slot  = ptr_w'(max_reads_p - 1);
    localparam logic [occ_w-1:0] fifo_depth = occ_w'(max_reads_p);

    bp_me_dma_arb_state_e state_q, state_d;
    logic [id_w-1:0]  rr_ptr_q, rr_ptr_d;
    logic [id_w-1:0]  wr_owner_q, wr_owner_d;
    logic [cnt_w-1:0] wr_cnt_q, wr_cnt_d;
    logic [cnt_w-1:0] rd_cnt_q, rd_cnt_d;
    logic [id_w-1:0]  fifo_mem_q [max_reads_p];
    logic [id_w-1:0]  fifo_mem_d [max_reads_p];
    logic [ptr_w-1:0] wptr_q, wptr_d;
    logic [ptr_w-1:0] rptr_q, rptr_d;
    logic [occ_w-1:0] occ_q, occ_d;

    logic                    fifo_ne;
    logic                    fifo_full;
    logic [id_w-1:0]         rd_owner;
    logic                    rd_hs;
    logic                    pop;
    logic                    push;
    logic                    in_arb;
    logic                    in_wr;
    logic [num_slices_p-1:0] arb_req;
    logic [num_slices_p-1:0] grant_oh;
    logic [id_w-1:0]         grant_id;
    logic                    grant_any;
    logic                    hdr_hs;
    logic                    wr_hs;
    logic                    unused_resp_hdr;

    assign unused_resp_hdr = ^{mem_resp_header_i, mem_resp_header_v_i};

    assign fifo_ne   = (occ_q != '0);
    assign fifo_full = (occ_q == fifo_depth);
    assign rd_owner  = fifo_mem_q[rptr_q];
    assign rd_hs     = reset_n_i & fifo_ne & mem_resp_data_v_i
                     & slice_resp_data_ready_i[rd_owner];
    assign pop       = rd_hs & (rd_cnt_q == last_beat);

    assign in_arb = reset_n_i & (state_q == e_arb);
    assign in_wr  = reset_n_i & (state_q == e_wr_data);

    // A full tracker still admits a read when the head block retires now.
    assign arb_req = in_arb
        ? (slice_cmd_header_v_i
           & (slice_cmd_wr_i | {num_slices_p{~fifo_full | pop}}))
        : '0;

    bp_me_rr_grant #(
        .num_p (num_slices_p)
    ) u_rr_grant (
        .req_i      (arb_req),
        .ptr_i      (rr_ptr_q),
        .grant_oh_o (grant_oh),
        .grant_id_o (grant_id),
        .any_o      (grant_any)
    );

    assign hdr_hs = grant_any & mem_cmd_header_yumi_i;
    assign push   = hdr_hs & ~slice_cmd_wr_i[grant_id];
    assign wr_hs  = in_wr & slice_cmd_data_v_i[wr_owner_q]
                  & mem_cmd_data_yumi_i;

    assign mem_cmd_header_v_o = grant_any;
    assign mem_cmd_header_o   =
        slice_cmd_header_i[grant_id*header_width_p +: header_width_p];
    assign slice_cmd_header_yumi_o = hdr_hs ? grant_oh : '0;

    assign mem_cmd_data_v_o = in_wr & slice_cmd_data_v_i[wr_owner_q];
    assign mem_cmd_data_o   =
        slice_cmd_data_i[wr_owner_q*data_width_p +: data_width_p];

    assign mem_resp_header_ready_o = reset_n_i;
    assign mem_resp_data_ready_o   = reset_n_i & fifo_ne
                                   & slice_resp_data_ready_i[rd_owner];
    assign slice_resp_data_o       = mem_resp_data_i;

    always_comb begin
        slice_cmd_data_yumi_o = '0;
        slice_resp_data_v_o   = '0;
        if (wr_hs) begin
            slice_cmd_data_yumi_o[wr_owner_q] = 1'b1;
        end
        if (reset_n_i && fifo_ne && mem_resp_data_v_i) begin
            slice_resp_data_v_o[rd_owner] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        wr_owner_d = wr_owner_q;
        wr_cnt_d   = wr_cnt_q;
        unique case (state_q)
            e_arb: begin
                if (hdr_hs) begin
                    rr_ptr_d = (grant_id == last_id) ? '0 : grant_id + 1'b1;
                    if (slice_cmd_wr_i[grant_id]) begin
                        wr_owner_d = grant_id;
                        wr_cnt_d   = '0;
                        state_d    = e_wr_data;
                    end
                end
            end
            e_wr_data: begin
                if (wr_hs) begin
                    if (wr_cnt_q == last_beat) begin
                        wr_cnt_d = '0;
                        state_d  = e_arb;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        rd_cnt_d   = rd_cnt_q;
        fifo_mem_d = fifo_mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        if (rd_hs) begin
            rd_cnt_d = pop ? '0 : rd_cnt_q + 1'b1;
        end
        if (push) begin
            fifo_mem_d[wptr_q] = grant_id;
            wptr_d = (wptr_q == last_slot) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == last_slot) ? '0 : rptr_q + 1'b1;
        end
        occ_d = occ_q + occ_w'(push) - occ_w'(pop);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_arb;
            rr_ptr_q   <= '0;
            wr_owner_q <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            occ_q      <= '0;
            for (int i = 0; i < max_reads_p; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_owner_q <= wr_owner_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            occ_q      <= occ_d;
            fifo_mem_q <= fifo_mem_d;
        end
    end

    // A read beat with nothing outstanding has no owner to go to.
    a_no_unsolicited: assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        mem_resp_data_v_i |-> fifo_ne
    ) else $error("unsolicited read beat");

endmodule

// File: tb/tb_bp_me_cache_dma_arbiter.sv
// Randomized bench for the cache DMA arbiter against a
// transaction-level reference model.
module tb_bp_me_cache_dma_arbiter;

    localparam int NS = 2;
    localparam int HW = 128;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int MR = 4;

    typedef struct {
        bit wr;
        int tag;
    } req_t;

    logic clk = 1'b0;
    logic rst_n;

    logic [NS*HW-1:0] hdr_in;
    logic [NS-1:0]    wr_in, hv_in, hyumi_o;
    logic [NS*DW-1:0] d_in;
    logic [NS-1:0]    dv_in, dyumi_o;
    logic [DW-1:0]    rdata_o;
    logic [NS-1:0]    rv_o, rrdy_in;
    logic [HW-1:0]    mh_o;
    logic             mhv_o, mhy_in;
    logic [DW-1:0]    md_o;
    logic             mdv_o, mdy_in;
    logic [HW-1:0]    rh_in;
    logic             rhv_in, rhr_o;
    logic [DW-1:0]    rd_in;
    logic             rdv_in, rdr_o;

    always #5 clk = ~clk;

    bp_me_cache_dma_arbiter #(
        .num_slices_p   (NS),
        .header_width_p (HW),
        .data_width_p   (DW),
        .block_words_p  (BW),
        .max_reads_p    (MR)
    ) dut (
        .clk_i                   (clk),
        .reset_n_i               (rst_n),
        .slice_cmd_header_i      (hdr_in),
        .slice_cmd_wr_i          (wr_in),
        .slice_cmd_header_v_i    (hv_in),
        .slice_cmd_header_yumi_o (hyumi_o),
        .slice_cmd_data_i        (d_in),
        .slice_cmd_data_v_i      (dv_in),
        .slice_cmd_data_yumi_o   (dyumi_o),
        .slice_resp_data_o       (rdata_o),
        .slice_resp_data_v_o     (rv_o),
        .slice_resp_data_ready_i (rrdy_in),
        .mem_cmd_header_o        (mh_o),
        .mem_cmd_header_v_o      (mhv_o),
        .mem_cmd_header_yumi_i   (mhy_in),
        .mem_cmd_data_o          (md_o),
        .mem_cmd_data_v_o        (mdv_o),
        .mem_cmd_data_yumi_i     (mdy_in),
        .mem_resp_header_i       (rh_in),
        .mem_resp_header_v_i     (rhv_in),
        .mem_resp_header_ready_o (rhr_o),
        .mem_resp_data_i         (rd_in),
        .mem_resp_data_v_i       (rdv_in),
        .mem_resp_data_ready_o   (rdr_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int tag_ctr = 1;

    // slice-side stimulus and scoreboards
    req_t sq[NS][$];
    int   s_left[NS];
    int   s_tag[NS];
    int   sexp[NS][$];
    int   sidx[NS];

    // DRAM-side read return queue
    int dq[$];
    int d_beat;

    // reference model
    bit m_wr;
    int m_owner, m_beat, m_tag, m_ptr, m_rd;
    int m_fifo[$];

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [HW-1:0] make_hdr(input int s, input int tag,
                                                input bit wr);
        logic [HW-1:0] h;
        h = '0;
        h[15:0]       = tag[15:0];
        h[23:16]      = s[7:0];
        h[24]         = wr;
        h[HW-1:HW-32] = 32'hC0DE_0000 ^ tag;
        return h;
    endfunction

    function automatic logic [DW-1:0] make_data(input int tag, input int idx);
        return {16'hBEEF, tag[15:0], idx[15:0], 16'h5A5A};
    endfunction

    task automatic clear_all();
        for (int i = 0; i < NS; i++) begin
            sq[i].delete();
            sexp[i].delete();
            s_left[i] = 0;
            s_tag[i]  = 0;
            sidx[i]   = 0;
        end
        dq.delete();
        d_beat  = 0;
        m_wr    = 1'b0;
        m_owner = 0;
        m_beat  = 0;
        m_tag   = 0;
        m_ptr   = 0;
        m_rd    = 0;
        m_fifo.delete();
    endtask

    task automatic quiet_inputs();
        hdr_in = '0; wr_in = '0; hv_in = '0;
        d_in = '0; dv_in = '0; rrdy_in = '0;
        mhy_in = 1'b0; mdy_in = 1'b0;
        rh_in = '0; rhv_in = 1'b0; rd_in = '0; rdv_in = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_hdr_v"},    mhv_o,   0);
        check({pfx, "_hdr_yumi"}, hyumi_o, 0);
        check({pfx, "_wr_v"},     mdv_o,   0);
        check({pfx, "_wr_yumi"},  dyumi_o, 0);
        check({pfx, "_rsp_v"},    rv_o,    0);
        check({pfx, "_rsp_rdy"},  rdr_o,   0);
        check({pfx, "_rhdr_rdy"}, rhr_o,   0);
    endtask

    task automatic do_cycle(input int new_pct, input int wr_pct,
                            input int resp_pct, input int rdy_pct);
        bit any, ne, rd_hs, pop, space, hdr_hs, wr_hs, exp_dv;
        int g, own, s;
        logic [HW-1:0] exp_hdr;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (sq[i].size() < 3 && $urandom_range(99) < new_pct) begin
                req_t r;
                r.wr = ($urandom_range(99) < wr_pct);
                r.tag = tag_ctr;
                tag_ctr++;
                sq[i].push_back(r);
            end
            if (sq[i].size() > 0 && s_left[i] == 0) begin
                hv_in[i] = 1'b1;
                wr_in[i] = sq[i][0].wr;
                hdr_in[i*HW +: HW] = make_hdr(i, sq[i][0].tag, sq[i][0].wr);
            end else begin
                hv_in[i] = 1'b0;
                wr_in[i] = 1'($urandom_range(1));
                hdr_in[i*HW +: HW] = {$urandom, $urandom, $urandom, $urandom};
            end
            if (s_left[i] > 0) begin
                dv_in[i] = ($urandom_range(99) < 75);
                d_in[i*DW +: DW] = make_data(s_tag[i], BW - s_left[i]);
            end else begin
                dv_in[i] = ($urandom_range(2) == 0);
                d_in[i*DW +: DW] = {$urandom, $urandom};
            end
            rrdy_in[i] = ($urandom_range(99) < rdy_pct);
        end
        if (dq.size() > 0 && $urandom_range(99) < resp_pct) begin
            rdv_in = 1'b1;
            rd_in  = make_data(dq[0], d_beat);
        end else begin
            rdv_in = 1'b0;
            rd_in  = {$urandom, $urandom};
        end
        rhv_in = 1'($urandom_range(1));
        rh_in  = {$urandom, $urandom, $urandom, $urandom};

        ne    = (m_fifo.size() > 0);
        own   = ne ? m_fifo[0] : 0;
        rd_hs = ne && rdv_in && rrdy_in[own];
        pop   = rd_hs && (m_rd == BW - 1);
        space = (m_fifo.size() < MR) || pop;
        any   = 1'b0;
        g     = 0;
        if (!m_wr) begin
            for (int k = 0; k < NS; k++) begin
                s = (m_ptr + k) % NS;
                if (!any && hv_in[s] && (wr_in[s] || space)) begin
                    any = 1'b1;
                    g   = s;
                end
            end
        end
        exp_hdr = any ? make_hdr(g, sq[g][0].tag, sq[g][0].wr) : '0;
        exp_dv  = m_wr && dv_in[m_owner];
        mhy_in  = any && ($urandom_range(99) < 70);
        mdy_in  = exp_dv && ($urandom_range(99) < 70);
        hdr_hs  = any && mhy_in;
        wr_hs   = exp_dv && mdy_in;
        #1;

        check("hdr_v", mhv_o, any);
        if (any) check("hdr", mh_o, exp_hdr);
        check("hdr_yumi", hyumi_o, hdr_hs ? (1 << g) : 0);
        check("wr_v", mdv_o, exp_dv);
        if (exp_dv) check("wr_data", md_o, make_data(m_tag, m_beat));
        check("wr_yumi", dyumi_o, wr_hs ? (1 << m_owner) : 0);
        check("rsp_rdy", rdr_o, ne && rrdy_in[own]);
        check("rsp_v", rv_o, (ne && rdv_in) ? (1 << own) : 0);
        if (ne && rdv_in) check("rsp_data", rdata_o, rd_in);
        check("rhdr_rdy", rhr_o, 1);

        for (int i = 0; i < NS; i++) begin
            if (rv_o[i] && rrdy_in[i]) begin
                if (sexp[i].size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    check("rd_order", rdata_o, make_data(sexp[i][0], sidx[i]));
                    sidx[i]++;
                    if (sidx[i] == BW) begin
                        sidx[i] = 0;
                        void'(sexp[i].pop_front());
                    end
                end
            end
        end

        if (rd_hs) begin
            d_beat++;
            if (d_beat == BW) begin
                d_beat = 0;
                void'(dq.pop_front());
            end
            m_rd++;
            if (m_rd == BW) begin
                m_rd = 0;
                void'(m_fifo.pop_front());
            end
        end
        if (wr_hs) begin
            s_left[m_owner]--;
            m_beat++;
            if (m_beat == BW) m_wr = 1'b0;
        end
        if (hdr_hs) begin
            req_t r;
            r = sq[g].pop_front();
            m_ptr = (g + 1) % NS;
            if (r.wr) begin
                m_wr      = 1'b1;
                m_owner   = g;
                m_beat    = 0;
                m_tag     = r.tag;
                s_left[g] = BW;
                s_tag[g]  = r.tag;
            end else begin
                m_fifo.push_back(g);
                dq.push_back(r.tag);
                sexp[g].push_back(r.tag);
            end
        end
    endtask

    function automatic bit busy();
        bit b;
        b = m_wr || (m_fifo.size() > 0) || (dq.size() > 0);
        for (int i = 0; i < NS; i++) begin
            b = b || (sq[i].size() > 0) || (sexp[i].size() > 0);
        end
        return b;
    endfunction

    initial begin
        bit hit;
        clear_all();
        quiet_inputs();
        rst_n = 1'b0;
        hv_in = '1; dv_in = '1; rrdy_in = '1;
        mhy_in = 1'b1; mdy_in = 1'b1; rhv_in = 1'b1; rdv_in = 1'b1;
        #3;
        check_all_zero("reset");
        @(posedge clk);
        quiet_inputs();
        @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (600) do_cycle(40, 40, 60, 80);
        repeat (150) do_cycle(70, 30, 0, 80);
        repeat (300) do_cycle(50, 30, 90, 90);
        repeat (400) do_cycle(40, 30, 80, 40);

        hit = 1'b0;
        for (int c = 0; c < 3000 && !hit; c++) begin
            do_cycle(60, 70, 50, 80);
            hit = m_wr && (m_beat == 3);
        end
        check("rst_reach_beat3", hit, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        clear_all();
        quiet_inputs();
        @(posedge clk);
        #1;
        check_all_zero("midrst_hold");
        @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (400) do_cycle(40, 40, 70, 80);

        for (int c = 0; c < 3000 && busy(); c++) begin
            do_cycle(0, 0, 100, 100);
        end
        check("drained", busy(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_me_cache_dma_arbiter.md
Name: bp_me_cache_dma_arbiter

Overview:
- Shares one DRAM DMA port (header + data channels) among num_slices_p L2 cache slices.
- Each slice presents its bsg_cache DMA request as a DRAM-style header plus write-data beats.
- Round-robin arbitration on headers; a write grant is held until its whole data burst has been forwarded.
- Read-response data beats are routed back to the requesting slice in request order, using an in-order tracking FIFO of slice ids.

Parameters:
- num_slices_p, 2, number of cache slices sharing the port (≥2).
- header_width_p, 128, DRAM mem header width in bits (opaque, passed through).
- data_width_p, 64, DMA data beat width.
- block_words_p, 8, data beats per block (cce_block_width/data_width).
- max_reads_p, 4, outstanding read blocks tracked; sets tracking FIFO depth.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- slice_cmd_header_i  in  num_slices_p*header_width_p  per-slice header, slice i at bits [i*hw +: hw].
- slice_cmd_wr_i  in  num_slices_p  per-slice: 1=write (data follows), 0=read.
- slice_cmd_header_v_i  in  num_slices_p  header valid.
- slice_cmd_header_yumi_o  out  num_slices_p  header consumed (one-hot or zero).
- slice_cmd_data_i  in  num_slices_p*data_width_p  per-slice write beat.
- slice_cmd_data_v_i  in  num_slices_p  write beat valid.
- slice_cmd_data_yumi_o  out  num_slices_p  write beat consumed.
- slice_resp_data_o  out  data_width_p  read beat, broadcast to all slices.
- slice_resp_data_v_o  out  num_slices_p  one-hot valid to the owning slice.
- slice_resp_data_ready_i  in  num_slices_p  slice ready for a read beat.
- mem_cmd_header_o  out  header_width_p  granted header.
- mem_cmd_header_v_o  out  1  header valid.
- mem_cmd_header_yumi_i  in  1  header consumed by DRAM.
- mem_cmd_data_o  out  data_width_p  write beat.
- mem_cmd_data_v_o  out  1  write beat valid.
- mem_cmd_data_yumi_i  in  1  write beat consumed.
- mem_resp_header_i  in  header_width_p  DRAM response header (ignored).
- mem_resp_header_v_i  in  1  response header valid.
- mem_resp_header_ready_o  out  1  always 1 outside reset.
- mem_resp_data_i  in  data_width_p  DRAM read beat.
- mem_resp_data_v_i  in  1  read beat valid.
- mem_resp_data_ready_o  out  1  ready for a read beat.

Behaviour:
- Reset (reset_n_i=0, asynchronous):
  - state=e_arb, rr_ptr=0, wr_cnt=0, rd_cnt=0, tracking FIFO empty.
  - All v/yumi/ready outputs 0, including mem_resp_header_ready_o. Data outputs are don't-care.
  - Reset asserted mid-burst abandons the burst; no recovery handshake.
- State e_arb:
  - Eligible slice: header_v=1 and (wr=1, or FIFO not full).
  - Grant = first eligible slice at or after rr_ptr, wrapping modulo num_slices_p.
  - Header path is combinational: mem_cmd_header_v_o = any eligible; mem_cmd_header_o = granted header.
  - Grant is recomputed each cycle until the handshake (no hold required before DRAM yumi).
  - On mem_cmd_header_yumi_i:
    - Assert slice_cmd_header_yumi_o[grant] the same cycle.
    - rr_ptr <= grant+1 (wraps).
    - Read: push grant id into FIFO; stay in e_arb.
    - Write: latch grant into wr_owner; wr_cnt <= 0; go to e_wr_data.
- State e_wr_data:
  - Headers blocked: mem_cmd_header_v_o=0.
  - mem_cmd_data_o/v_o = slice_cmd_data_i/v_i of wr_owner.
  - slice_cmd_data_yumi_o[wr_owner] = mem_cmd_data_yumi_i.
  - Each beat increments wr_cnt. The beat with wr_cnt==block_words_p-1 returns to e_arb the next cycle.
  - Data from non-owner slices is never consumed.
- State e_arb drives no write data: mem_cmd_data_v_o=0.
- Read return path (runs concurrently with both states):
  - owner = FIFO head.
  - mem_resp_data_ready_o = FIFO nonempty & slice_resp_data_ready_i[owner].
  - slice_resp_data_v_o[owner] = mem_resp_data_v_i & FIFO nonempty; slice_resp_data_o = mem_resp_data_i.
  - Each handshake increments rd_cnt. At rd_cnt==block_words_p-1: pop FIFO, rd_cnt <= 0.
  - Push and pop in the same cycle are legal, including when the FIFO is full.
  - FIFO full blocks read headers only; writes still proceed.
- Response headers are accepted unconditionally and dropped.
- Beats with FIFO empty are unsolicited; assertion error.
- Latency: zero added cycles on every path (pure muxing); state changes take effect next cycle.
- Counter widths: wr_cnt and rd_cnt are $clog2(block_words_p) bits; rr_ptr is $clog2(num_slices_p) bits, with explicit wrap when num_slices_p is not a power of two.

Decomposition:
- bp_me_pkg gains the state enum bp_me_dma_arb_state_e {e_arb, e_wr_data}.
- Slice-id tracking uses bsg_fifo_1r1w_small (els=max_reads_p, width=slice id width).
- Round-robin grant logic is a sub-module bp_me_rr_grant: inputs request vector and rr_ptr; outputs one-hot grant, grant id, any.

Test Plan:
- Slices 0,1 each issue one read simultaneously, DRAM returns 16 beats 0x0..0xF → slice0 gets beats 0x0..0x7, slice1 gets 0x8..0xF; header order 0 then 1.
- Slice1 write (beats 0xA0..0xA7) while slice0 read pending → headers wr1 then rd0; no header issued during the 8 write beats; data forwarded in order.
- Slice0 holds header_v continuously with 4 requests, slice1 1 request → grants 0,1,0,0,0 (fairness after rr_ptr advance).
- Four reads outstanding (max_reads_p=4), slice1 issues fifth read and slice0 a write → read stalled, write header accepted; read issued the cycle the first block's last beat pops.
- slice_resp_data_ready_i[owner]=0 for 3 cycles mid-block → mem_resp_data_ready_o=0 for those cycles; no beat lost or duplicated.
- reset_n_i pulsed low at write beat 3 → all outputs 0 immediately; after release, state=e_arb, FIFO empty, fresh read is granted.
